// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for COM symbols bit by bit, locks byte alignment
// after ALIGN_COUNT consecutive aligned COMs, then emits one byte per 8 sclk cycles.
module serial_paralelo_rx #(
    parameter logic [7:0] COM         = 8'hBC,
    parameter int         ALIGN_COUNT = 4
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_COUNT);

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_strobe;
    logic       r_active;

    logic [7:0] w_nxt;
    logic       w_is_com;
    logic       w_boundary;
    logic [3:0] w_com_inc;

    // Every decision looks at the byte that includes the bit arriving on this edge.
    assign w_nxt      = {r_sr[6:0], serial_in};
    assign w_is_com   = (w_nxt == COM);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_com_inc  = r_com_cnt + 4'd1;

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_sr <= w_nxt;
            case (r_state)
                SEARCH: begin
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= 4'd1;
                        if (ALIGN_TARGET == 4'd1) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_com_cnt <= w_com_inc;
                            if (w_com_inc == ALIGN_TARGET) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_com_cnt <= 4'd0;
                            r_state   <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        r_data   <= w_nxt;
                        r_valid  <= !w_is_com;
                        r_strobe <= 1'b1;
                    end else begin
                        r_strobe <= 1'b0;
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: two instances (ALIGN_COUNT 4 and 1) share one stream and
// are checked every cycle against a reference model built on absolute bit positions.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;

    logic       sclk;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out  [2];
    logic       valid_out [2];
    logic       byte_strobe [2];
    logic       active    [2];
    logic [1:0] dbg_state [2];

    int n_cmp;
    int n_err;

    serial_paralelo_rx #(.COM(COM), .ALIGN_COUNT(4)) u_dut4 (
        .sclk(sclk), .reset(reset), .serial_in(serial_in),
        .data_out(data_out[0]), .valid_out(valid_out[0]), .byte_strobe(byte_strobe[0]),
        .active(active[0]), .dbg_state(dbg_state[0])
    );

    serial_paralelo_rx #(.COM(COM), .ALIGN_COUNT(1)) u_dut1 (
        .sclk(sclk), .reset(reset), .serial_in(serial_in),
        .data_out(data_out[1]), .valid_out(valid_out[1]), .byte_strobe(byte_strobe[1]),
        .active(active[1]), .dbg_state(dbg_state[1])
    );

    // clock / reset
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // reference model: lock mode, bit time of the first COM, aligned-COM count
    int         t;
    logic [7:0] m_win;
    int         m_mode   [2];
    int         m_anchor [2];
    int         m_coms   [2];
    logic [7:0] m_data   [2];
    logic       m_valid  [2];
    logic       m_strobe [2];
    logic       m_active [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_win = 8'h00;
        for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_anchor[i] = 0;
            m_coms[i]   = 0;
            m_data[i]   = 8'h00;
            m_valid[i]  = 1'b0;
            m_strobe[i] = 1'b0;
            m_active[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int  ac;
        bit  on_byte;
        ac      = (i == 0) ? 4 : 1;
        on_byte = ((t - m_anchor[i]) % 8) == 0;
        case (m_mode[i])
            0: if (m_win == COM) begin
                m_anchor[i] = t;
                m_coms[i]   = 1;
                if (m_coms[i] == ac) begin
                    m_mode[i]   = 2;
                    m_active[i] = 1'b1;
                end else begin
                    m_mode[i] = 1;
                end
            end
            1: if (on_byte) begin
                if (m_win == COM) begin
                    m_coms[i]++;
                    if (m_coms[i] == ac) begin
                        m_mode[i]   = 2;
                        m_active[i] = 1'b1;
                    end
                end else begin
                    m_coms[i] = 0;
                    m_mode[i] = 0;
                end
            end
            default: begin
                m_strobe[i] = on_byte;
                if (on_byte) begin
                    m_data[i]  = m_win;
                    m_valid[i] = (m_win != COM);
                end
            end
        endcase
    endtask

    // driver tasks: one bit per cycle, applied on negedge, checked 1 ns after posedge
    task automatic drive(input bit b, input bit rst);
        @(negedge sclk);
        serial_in = b;
        reset     = rst;
        @(posedge sclk);
        t++;
        if (rst) begin
            model_reset();
        end else begin
            m_win = {m_win[6:0], b};
            for (int i = 0; i < 2; i++) model_step(i);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("data%0d", i),   data_out[i],          m_data[i]);
            check($sformatf("valid%0d", i),  {7'd0, valid_out[i]}, {7'd0, m_valid[i]});
            check($sformatf("strobe%0d", i), {7'd0, byte_strobe[i]}, {7'd0, m_strobe[i]});
            check($sformatf("active%0d", i), {7'd0, active[i]},    {7'd0, m_active[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) drive(b[k], 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) drive(1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        n_cmp     = 0;
        n_err     = 0;
        t         = 0;
        serial_in = 1'b0;
        reset     = 1'b1;
        model_reset();

        // reset then idle zeros
        do_reset(2);
        check("rst_data", data_out[0], 8'h00);
        check("rst_active", {7'd0, active[0]}, 8'h00);
        for (int k = 0; k < 64; k++) drive(1'b0, 1'b0);
        check("idle_active", {7'd0, active[0]}, 8'h00);

        // lock at bit offset 3
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(COM);
        check("lock_active", {7'd0, active[0]}, 8'h01);
        send_byte(8'hFF);
        check("lock_ff", data_out[0], 8'hFF);
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hCC);
        check("lock_cc", data_out[0], 8'hCC);

        // idle symbol inside data
        send_byte(8'h99);
        send_byte(COM);
        check("idle_valid", {7'd0, valid_out[0]}, 8'h00);
        send_byte(8'h88);
        check("idle_88", data_out[0], 8'h88);

        // broken alignment
        do_reset(1);
        send_byte(COM); send_byte(COM); send_byte(8'h12);
        check("broken_active", {7'd0, active[0]}, 8'h00);
        for (int k = 0; k < 4; k++) send_byte(COM);
        send_byte(8'hAA);
        check("relock_aa", data_out[0], 8'hAA);

        // reset in the middle of a data byte
        for (int k = 7; k >= 4; k--) drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        check("midrst_active", {7'd0, active[0]}, 8'h00);
        check("midrst_data", data_out[0], 8'h00);
        for (int k = 0; k < 3; k++) send_byte(COM);
        send_byte(8'h77);
        check("midrst_nolock", {7'd0, active[0]}, 8'h00);
        for (int k = 0; k < 4; k++) send_byte(COM);
        send_byte(8'h77);
        check("midrst_77", data_out[0], 8'h77);

        // randomized rounds: junk offset, some COMs, mixed payload
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
            for (int k = $urandom_range(0, 7); k > 0; k--) drive(1'($urandom_range(0, 1)), 1'b0);
            for (int k = $urandom_range(0, 5); k > 0; k--) send_byte(COM);
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
                rb = ($urandom_range(0, 4) == 0) ? COM : 8'($urandom_range(0, 255));
                send_byte(rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side serial-to-parallel converter that sits directly upstream of the L2 byte demux.
- Shifts in a 1-bit serial stream on a bit-rate clock (8x the byte clock), finds byte alignment using COM symbols, and then delivers 8-bit words with a valid flag.
- Outputs: data_out, valid_out and a byte_strobe that marks the byte-clock rate for the downstream demux.

Parameters:
- COM, 8'hBC, comma/idle symbol used for alignment; never forwarded as valid data.
- ALIGN_COUNT, 4, number of consecutive aligned COM bytes required to declare lock (legal range 1..15).

Ports:
- sclk  input  1  bit-rate clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit, MSB first, sampled every sclk posedge.
- data_out  output  8  last completed byte (registered).
- valid_out  output  1  high for the byte period when data_out holds a non-COM byte in ACTIVE.
- byte_strobe  output  1  one-sclk pulse on each byte boundary while active.
- active  output  1  high once alignment lock is achieved.

Behaviour:
- Clocking and reset: one clock (sclk); reset is synchronous and active-high.
- Reset (sampled high at a posedge):
  - state=SEARCH; shift register, bit_cnt and com_cnt = 0.
  - data_out=8'h00; valid_out=0; byte_strobe=0; active=0.
  - Reset overrides all other activity at that edge, including mid-byte and in ACTIVE; realignment then restarts from SEARCH.
- Shift register and candidate byte:
  - Every posedge: sr <= {sr[6:0], serial_in}.
  - nxt = {sr[6:0], serial_in} is the candidate byte used by every comparison.
- SEARCH:
  - Bit-granular hunt: compare nxt==COM on every edge.
  - On match: bit_cnt<=0, com_cnt<=1, go to ALIGN.
  - If ALIGN_COUNT==1, go directly to ACTIVE instead.
- ALIGN:
  - bit_cnt increments 0..7 and wraps to 0.
  - A byte boundary is the edge where bit_cnt==7.
  - At a boundary with nxt==COM: com_cnt++. If the new com_cnt==ALIGN_COUNT, go to ACTIVE and set active<=1 at that same edge.
  - At a boundary with nxt!=COM: com_cnt<=0, return to SEARCH.
  - The SEARCH comparison is first applied at the following edge, not the failing one.
  - Between boundaries: no comparison.
- ACTIVE (held until reset; there is no loss-of-lock exit):
  - bit_cnt continues 0..7.
  - At each boundary: data_out<=nxt; valid_out<=(nxt!=COM); byte_strobe<=1.
  - At other edges: byte_strobe<=0; data_out and valid_out hold.
  - The COM byte that completes lock is not output. The first strobe occurs 8 sclk cycles after active rises.
- Latency: the last bit of a byte sampled at edge k appears on data_out/valid_out after edge k, i.e. zero added cycles beyond the register.
- Timing: byte_strobe is high for exactly 1 of every 8 cycles in ACTIVE. valid_out is a level for the whole byte period, matching the demux's cclk-rate valid.
- Boundary cases:
  - COM bit pattern straddling an aligned boundary while in ALIGN: ignored (only boundary-edge comparisons count).
  - Data bytes equal to COM in ACTIVE: output with valid_out=0, and the stream keeps flowing.
  - serial_in X/Z: not handled; the bench must drive known values.

Test Plan:
- Reset then idle zeros: reset high 2 cycles, then serial_in=0 for 64 cycles -> active=0, valid_out=0, byte_strobe=0, data_out=8'h00 throughout.
- Lock at offset 3: 3 junk bits (1,0,1), then 4x 8'hBC, then 8'hFF, 8'hDD, 8'hEE, 8'hCC -> active rises on the edge of the 4th BC's last bit. Then byte_strobe pulses every 8 cycles with data_out FF, DD, EE, CC and valid_out=1 on each.
- Broken alignment: BC, BC, 8'h12, then 4x BC, then 8'hAA -> no lock after the 12 (return to SEARCH, com_cnt cleared). Lock after the next four BCs; data_out=AA, valid_out=1.
- Idle inside data: in ACTIVE send 8'h99, 8'hBC, 8'h88 -> data_out 99/BC/88 with valid_out 1/0/1; byte_strobe keeps the 8-cycle cadence.
- Reset mid-byte in ACTIVE: assert reset at bit 4 of a data byte -> next edge active=0, valid_out=0, data_out=00. Re-lock requires 4 fresh BCs.
- Parameter ALIGN_COUNT=1: single BC then 8'h77 -> active high on the edge completing BC; data_out=77, valid_out=1 eight cycles later.
